// File: rtl/mems_dac_seq.sv
// mems_dac_seq: walks the MEMS DAC command ROM and streams each 24-bit
// command word MSB-first to a quad DAC over a 3-wire SPI link.
// The full init sequence runs once after reset. Each start request then
// runs the channel-update sequence.
module mems_dac_seq #(
  parameter int CLK_DIV    = 4,
  parameter int N_WORDS    = 7,
  parameter int INIT_WORDS = 2,
  parameter int SYNC_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        sclk,
  output logic        sync_n,
  output logic        mosi,
  output logic        busy,
  output logic        init_done,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic {
    SEQ_INIT   = 1'b0,
    SEQ_UPDATE = 1'b1
  } seq_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(SYNC_GAP - 1);
  localparam logic [3:0]  LAST_ADDR = 4'(N_WORDS - 1);
  localparam logic [3:0]  UPD_ADDR  = 4'(INIT_WORDS);

  state_t      state_r;
  seq_t        seq_r;
  logic [3:0]  rom_addr_r;
  logic        sclk_r;
  logic        sync_n_r;
  logic        busy_r;
  logic        init_done_r;
  logic        done_r;
  logic        pending_r;
  logic        fetch_ph_r;   // 0: address settling, 1: capture cycle
  logic        tail_r;       // trailing cycle with sclk high, sync_n still low
  logic [15:0] div_cnt_r;
  logic [15:0] gap_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [23:0] shift_r;      // bit 23 is the bit currently on the wire

  assign rom_addr  = rom_addr_r;
  assign sclk      = sclk_r;
  assign sync_n    = sync_n_r;
  assign mosi      = shift_r[23];
  assign busy      = busy_r;
  assign init_done = init_done_r;
  assign done      = done_r;

  // Sequencer FSM, SPI bit timing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FETCH;
      seq_r       <= SEQ_INIT;
      rom_addr_r  <= 4'd0;
      sclk_r      <= 1'b1;
      sync_n_r    <= 1'b1;
      busy_r      <= 1'b1;
      init_done_r <= 1'b0;
      done_r      <= 1'b0;
      pending_r   <= 1'b0;
      fetch_ph_r  <= 1'b0;
      tail_r      <= 1'b0;
      div_cnt_r   <= 16'd0;
      gap_cnt_r   <= 16'd0;
      bit_cnt_r   <= 5'd0;
      shift_r     <= 24'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          shift_r  <= 24'd0;
          if (start || pending_r) begin
            // A start arriving together with done lands here directly,
            // so busy never drops between back-to-back sequences.
            pending_r  <= 1'b0;
            rom_addr_r <= UPD_ADDR;
            seq_r      <= SEQ_UPDATE;
            fetch_ph_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_FETCH;
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (start) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          if (!fetch_ph_r) begin
            fetch_ph_r <= 1'b1;
          end else begin
            fetch_ph_r <= 1'b0;
            shift_r    <= rom_data;
            sync_n_r   <= 1'b0;
            sclk_r     <= 1'b1;
            bit_cnt_r  <= 5'd23;
            div_cnt_r  <= 16'd0;
            tail_r     <= 1'b0;
            state_r    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (start) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          if (tail_r) begin
            tail_r    <= 1'b0;
            sync_n_r  <= 1'b1;
            shift_r   <= 24'd0;
            gap_cnt_r <= 16'd0;
            state_r   <= ST_GAP;
          end else if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end else begin
            div_cnt_r <= 16'd0;
            if (sclk_r) begin
              // End of high half: falling edge, the DAC samples here.
              sclk_r <= 1'b0;
            end else begin
              // End of low half: rising edge, present the next bit.
              sclk_r <= 1'b1;
              if (bit_cnt_r == 5'd0) begin
                tail_r <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r - 5'd1;
                shift_r   <= {shift_r[22:0], 1'b0};
              end
            end
          end
        end

        ST_GAP: begin
          if (start) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          shift_r  <= 24'd0;
          if (gap_cnt_r != GAP_LAST) begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end else begin
            gap_cnt_r <= 16'd0;
            if (rom_addr_r < LAST_ADDR) begin
              rom_addr_r <= rom_addr_r + 4'd1;
              fetch_ph_r <= 1'b0;
              state_r    <= ST_FETCH;
            end else begin
              // Last word sent: rom_addr holds, busy drops a cycle later.
              done_r <= 1'b1;
              if (seq_r == SEQ_INIT) begin
                init_done_r <= 1'b1;
              end else begin
                init_done_r <= init_done_r;
              end
              state_r <= ST_IDLE;
            end
          end
        end

        default: begin
          // Unreachable encoding: park safely with the link idle.
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          shift_r  <= 24'd0;
          busy_r   <= 1'b1;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mems_dac_seq.sv
// Self-checking bench for mems_dac_seq: a registered ROM model, an SPI
// frame decoder working from the wire waveform, and directed sequences
// with randomized ROM contents.
module tb_mems_dac_seq;

  localparam int CLK_DIV    = 2;
  localparam int N_WORDS    = 7;
  localparam int INIT_WORDS = 2;
  localparam int SYNC_GAP   = 4;
  localparam int FRAME_LOW  = 48 * CLK_DIV + 1;
  localparam int FRAME_GAP  = SYNC_GAP + 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rom_addr;
  logic [23:0] rom_data;
  logic        sclk, sync_n, mosi, busy, init_done, done;

  logic [23:0] rom_img [16];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] word;
    int          low;
    int          falls;
    int          bad;
    int          gap;
  } frame_t;

  frame_t frames[$];
  int done_cnt     = 0;
  int busy_low_cnt = 0;
  int idle_bad     = 0;
  int mon_falls    = 0;

  always #5 clk = ~clk;

  mems_dac_seq #(
    .CLK_DIV(CLK_DIV), .N_WORDS(N_WORDS),
    .INIT_WORDS(INIT_WORDS), .SYNC_GAP(SYNC_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sclk(sclk), .sync_n(sync_n), .mosi(mosi),
    .busy(busy), .init_done(init_done), .done(done)
  );

  // Registered command ROM: data valid one clock after the address.
  always @(posedge clk) rom_data <= rom_img[rom_addr];

  // Wire-level SPI decoder: rebuilds each frame from sclk/sync_n/mosi.
  initial begin
    logic        prev_sync, prev_sclk, prev_mosi;
    logic [23:0] cur_word;
    int low_cnt, hi_cnt, last_fall, cyc, bad_cnt, gap_before;
    frame_t f;
    prev_sync = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
    cur_word = 24'd0; low_cnt = 0; hi_cnt = 0; last_fall = -1;
    cyc = 0; bad_cnt = 0; gap_before = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        frames.delete();
        prev_sync = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0;
        hi_cnt = 0; mon_falls = 0;
      end else begin
        if (busy === 1'b0) busy_low_cnt++;
        if (done === 1'b1) done_cnt++;
        if (sync_n === 1'b1 && sclk !== 1'b1) idle_bad++;
        if (sync_n === 1'b0) begin
          if (prev_sync) begin
            cur_word = 24'd0; low_cnt = 0; mon_falls = 0; bad_cnt = 0;
            last_fall = -1; gap_before = hi_cnt;
          end else if (mosi !== prev_mosi && !(sclk === 1'b1 && prev_sclk === 1'b0)) begin
            bad_cnt++;
          end
          low_cnt++;
          if (prev_sclk === 1'b1 && sclk === 1'b0) begin
            cur_word = {cur_word[22:0], mosi};
            mon_falls++;
            if (last_fall >= 0 && (cyc - last_fall) != 2 * CLK_DIV) bad_cnt++;
            last_fall = cyc;
          end
        end else begin
          if (!prev_sync) begin
            f.word = cur_word; f.low = low_cnt; f.falls = mon_falls;
            f.bad = bad_cnt; f.gap = gap_before;
            frames.push_back(f);
            hi_cnt = 0;
          end
          hi_cnt++;
        end
        prev_sync = sync_n; prev_sclk = sclk; prev_mosi = mosi;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done_to(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic load_rom();
    rom_img[0] = 24'h280000;
    rom_img[1] = 24'h000000;
    for (int i = INIT_WORDS; i < N_WORDS; i++)
      rom_img[i] = {8'h18 + 8'(i), 8'($urandom_range(0, 255)), 8'h00};
    for (int i = N_WORDS; i < 16; i++) rom_img[i] = 24'hFFFFFF;
  endtask

  // Expected frames: consecutive ROM words starting at 'first'.
  task automatic check_frames(input int base, input int first, input int n, input string tag);
    frame_t f;
    chk({tag, "_nframes"}, 32'(frames.size() >= base + n), 32'd1);
    if (frames.size() >= base + n) begin
      for (int i = 0; i < n; i++) begin
        f = frames[base + i];
        chk({tag, "_word"},  32'(f.word), 32'(rom_img[first + i]));
        chk({tag, "_low"},   32'(f.low), 32'(FRAME_LOW));
        chk({tag, "_falls"}, 32'(f.falls), 32'd24);
        chk({tag, "_timing"}, 32'(f.bad), 32'd0);
        if (i > 0) chk({tag, "_gap"}, 32'(f.gap), 32'(FRAME_GAP));
      end
    end
  endtask

  initial begin
    int d0, bl0, base, n;

    // Test 1: reset state, then the full init sequence.
    load_rom();
    rst = 1'b1;
    steps(3);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_sync", 32'(sync_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_initdone", 32'(init_done), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    d0 = done_cnt;
    rst = 1'b0;
    wait_done_to(d0 + 1, 2000, "t1_timeout");
    chk("t1_busy_at_done", 32'(busy), 32'd1);
    chk("t1_nframes", 32'(frames.size()), 32'd7);
    check_frames(0, 0, 7, "t1");
    step();
    chk("t1_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_initdone", 32'(init_done), 32'd1);
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_addr_hold", 32'(rom_addr), 32'd6);

    // Test 3: update with delta_A = 0xA5.
    rom_img[2] = 24'h1AA500;
    base = frames.size();
    d0 = done_cnt;
    pulse_start();
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_addr", 32'(rom_addr), 32'(INIT_WORDS));
    wait_done_to(d0 + 1, 1500, "t3_timeout");
    check_frames(base, 2, 5, "t3");
    if (frames.size() > base) chk("t3_first_word", 32'(frames[base].word), 32'h1AA500);
    step();
    chk("t3_nframes", 32'(frames.size() - base), 32'd5);
    chk("t3_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t3_busy_after", 32'(busy), 32'd0);

    // Test 6: start in the same cycle as done of an update.
    load_rom();
    d0 = done_cnt;
    pulse_start();
    wait_done_to(d0 + 1, 1500, "t6_timeout1");
    start = 1'b1;
    bl0 = busy_low_cnt;
    base = frames.size();
    step();
    start = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_addr", 32'(rom_addr), 32'(INIT_WORDS));
    wait_done_to(d0 + 2, 1500, "t6_timeout2");
    chk("t6_busy_gapless", 32'(busy_low_cnt - bl0), 32'd0);
    check_frames(base, 2, 5, "t6");
    steps(50);
    chk("t6_ndone", 32'(done_cnt - d0), 32'd2);
    chk("t6_busy_after", 32'(busy), 32'd0);

    // Test 4: three starts during init collapse to one update.
    load_rom();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    d0 = done_cnt;
    bl0 = busy_low_cnt;
    steps(40);
    pulse_start();
    steps(300);
    pulse_start();
    steps(300);
    pulse_start();
    chk("t4_still_init", 32'(init_done), 32'd0);
    wait_done_to(d0 + 2, 4000, "t4_timeout");
    chk("t4_busy_high", 32'(busy_low_cnt - bl0), 32'd0);
    chk("t4_nframes", 32'(frames.size()), 32'd12);
    check_frames(0, 0, 7, "t4_init");
    check_frames(7, 2, 5, "t4_upd");
    step();
    chk("t4_busy_after", 32'(busy), 32'd0);
    steps(50);
    chk("t4_ndone", 32'(done_cnt - d0), 32'd2);

    // Test 5: reset during bit 10 of frame 3 of an update.
    base = frames.size();
    pulse_start();
    n = 0;
    while (!(frames.size() == base + 3 && mon_falls == 13 && sclk === 1'b1 && sync_n === 1'b0)
           && n < 3000) begin
      step();
      n++;
    end
    chk("t5_reached_bit10", 32'(n < 3000), 32'd1);
    load_rom();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_sync", 32'(sync_n), 32'd1);
    chk("t5_sclk", 32'(sclk), 32'd1);
    chk("t5_initdone", 32'(init_done), 32'd0);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    wait_done_to(d0 + 1, 2000, "t5_timeout");
    chk("t5_nframes", 32'(frames.size()), 32'd7);
    check_frames(0, 0, 7, "t5");
    step();
    chk("t5_initdone_after", 32'(init_done), 32'd1);
    chk("t5_busy_after", 32'(busy), 32'd0);
    chk("idle_sclk_high", 32'(idle_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
